run_debug_ctrl: RTL and testbench



---
 rtl/run_debug_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_run_debug_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_debug_ctrl.sv
// Run controller between the debug host command decoder and the datapath.
// Gates the datapath enable (continuous / single-step / run-to-breakpoint), confirms HLT, counts enabled cycles.
module run_debug_ctrl #(
  parameter int                   PROC_BITS        = 32,
  parameter int                   PC_BITS          = 32,
  parameter int                   CLK_COUNTER_BITS = 32,
  parameter int                   HALT_CONFIRM     = 3,
  parameter logic [PROC_BITS-1:0] HLT_WORD         = 32'hFFFF_FFFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [1:0]                  i_mode,
  input  logic                        i_step,
  input  logic                        i_abort,
  input  logic                        i_bp_en,
  input  logic [PC_BITS-1:0]          i_bp_addr,
  input  logic [PC_BITS-1:0]          i_pc,
  input  logic [PROC_BITS-1:0]        i_instruction,
  input  logic                        i_send_done,
  output logic                        o_enable,
  output logic                        o_send_start,
  output logic [CLK_COUNTER_BITS-1:0] o_clk_count,
  output logic [1:0]                  o_stop_cause,
  output logic                        o_busy,
  output logic                        o_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_CHECK_HLT = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_STEP_EXEC = 3'd4,
    S_SEND      = 3'd5,
    S_WAIT_SEND = 3'd6,
    S_FINISH    = 3'd7
  } state_e;

  localparam logic [3:0]                  CONFIRM   = 4'(HALT_CONFIRM);
  localparam logic [CLK_COUNTER_BITS-1:0] COUNT_MAX = {CLK_COUNTER_BITS{1'b1}};
  localparam logic [CLK_COUNTER_BITS-1:0] COUNT_ONE = CLK_COUNTER_BITS'(1);

  localparam logic [1:0] CAUSE_STEP  = 2'd0;
  localparam logic [1:0] CAUSE_HALT  = 2'd1;
  localparam logic [1:0] CAUSE_BP    = 2'd2;
  localparam logic [1:0] CAUSE_ABORT = 2'd3;

  state_e                      state_q, state_d;
  logic [1:0]                  mode_q, mode_d;
  logic [3:0]                  halt_cnt_q, halt_cnt_d;
  logic [1:0]                  cause_q, cause_d;
  logic [CLK_COUNTER_BITS-1:0] count_q, count_d;

  logic       is_hlt_s;
  logic       bp_hit_s;
  logic [3:0] halt_inc_s;
  logic [3:0] step_halt_s;

  assign is_hlt_s    = (i_instruction == HLT_WORD);
  assign bp_hit_s    = (mode_q == 2'd2) && i_bp_en && (i_pc == i_bp_addr);
  assign halt_inc_s  = halt_cnt_q + 4'd1;
  assign step_halt_s = is_hlt_s ? halt_inc_s : 4'd0;

  // Moore output decode from the current state.
  always_comb begin
    o_enable     = 1'b0;
    o_send_start = 1'b0;
    o_done       = 1'b0;
    o_busy       = 1'b1;
    case (state_q)
      S_IDLE:      o_busy       = 1'b0;
      S_RUN:       o_enable     = 1'b1;
      S_CHECK_HLT: o_enable     = 1'b1;
      S_STEP_WAIT: o_enable     = 1'b0;
      S_STEP_EXEC: o_enable     = 1'b1;
      S_SEND:      o_send_start = 1'b1;
      S_WAIT_SEND: o_enable     = 1'b0;
      S_FINISH:    o_done       = 1'b1;
      default:     o_busy       = 1'b0;
    endcase
  end

  // Next-state, mode, halt-confirm counter, stop cause and cycle counter.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    halt_cnt_d = halt_cnt_q;
    cause_d    = cause_q;
    if (o_enable && (count_q != COUNT_MAX)) begin
      count_d = count_q + COUNT_ONE;
    end else begin
      count_d = count_q;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mode_d     = (i_mode == 2'd3) ? 2'd0 : i_mode;
          count_d    = '0;
          halt_cnt_d = 4'd0;
          state_d    = (i_mode == 2'd1) ? S_STEP_WAIT : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          cause_d = CAUSE_ABORT;
          state_d = S_SEND;
        end else if (is_hlt_s) begin
          halt_cnt_d = 4'd1;
          if (CONFIRM == 4'd1) begin
            cause_d = CAUSE_HALT;
            state_d = S_SEND;
          end else begin
            state_d = S_CHECK_HLT;
          end
        end else if (bp_hit_s) begin
          cause_d = CAUSE_BP;
          state_d = S_SEND;
        end else begin
          state_d = S_RUN;
        end
      end
      // Breakpoints are deliberately not evaluated while confirming a halt.
      S_CHECK_HLT: begin
        if (i_abort) begin
          cause_d = CAUSE_ABORT;
          state_d = S_SEND;
        end else if (is_hlt_s) begin
          halt_cnt_d = halt_inc_s;
          if (halt_inc_s == CONFIRM) begin
            cause_d = CAUSE_HALT;
            state_d = S_SEND;
          end else begin
            state_d = S_CHECK_HLT;
          end
        end else begin
          halt_cnt_d = 4'd0;
          state_d    = S_RUN;
        end
      end
      S_STEP_WAIT: begin
        if (i_abort) begin
          cause_d = CAUSE_ABORT;
          state_d = S_SEND;
        end else if (i_step) begin
          state_d = S_STEP_EXEC;
        end else begin
          state_d = S_STEP_WAIT;
        end
      end
      // The halt count carries over between single steps.
      S_STEP_EXEC: begin
        halt_cnt_d = step_halt_s;
        cause_d    = (step_halt_s == CONFIRM) ? CAUSE_HALT : CAUSE_STEP;
        state_d    = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT_SEND;
      end
      S_WAIT_SEND: begin
        if (i_send_done) begin
          state_d = (cause_q == CAUSE_STEP) ? S_STEP_WAIT : S_FINISH;
        end else begin
          state_d = S_WAIT_SEND;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'd0;
      halt_cnt_q <= 4'd0;
      cause_q    <= 2'd0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      halt_cnt_q <= halt_cnt_d;
      cause_q    <= cause_d;
      count_q    <= count_d;
    end
  end

  assign o_clk_count  = count_q;
  assign o_stop_cause = cause_q;

endmodule

// File: tb/tb_run_debug_ctrl.sv
// Self-checking bench for run_debug_ctrl: per-scenario cycle tables plus a
// scoreboard of expected {count, cause} records consumed on every send_start.
module tb_run_debug_ctrl;

  localparam logic [31:0] HLT  = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [1:0]  i_mode;
  logic        i_step;
  logic        i_abort;
  logic        i_bp_en;
  logic [31:0] i_bp_addr;
  logic [31:0] i_pc;
  logic [31:0] i_instruction;
  logic        i_send_done;

  logic        o_enable, o_send_start, o_busy, o_done;
  logic [31:0] o_clk_count;
  logic [1:0]  o_stop_cause;

  logic        s_enable, s_send_start, s_busy, s_done;
  logic [3:0]  s_clk_count;
  logic [1:0]  s_stop_cause;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] count;
    logic [1:0]  cause;
  } exp_t;
  exp_t sb[$];

  run_debug_ctrl dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_step(i_step),
    .i_abort(i_abort), .i_bp_en(i_bp_en), .i_bp_addr(i_bp_addr), .i_pc(i_pc),
    .i_instruction(i_instruction), .i_send_done(i_send_done),
    .o_enable(o_enable), .o_send_start(o_send_start), .o_clk_count(o_clk_count),
    .o_stop_cause(o_stop_cause), .o_busy(o_busy), .o_done(o_done)
  );

  run_debug_ctrl #(.CLK_COUNTER_BITS(4)) dut_sat (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_step(i_step),
    .i_abort(i_abort), .i_bp_en(i_bp_en), .i_bp_addr(i_bp_addr), .i_pc(i_pc),
    .i_instruction(i_instruction), .i_send_done(i_send_done),
    .o_enable(s_enable), .o_send_start(s_send_start), .o_clk_count(s_clk_count),
    .o_stop_cause(s_stop_cause), .o_busy(s_busy), .o_done(s_done)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every send_start must match the oldest expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_send_start === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_send count=%0d cause=%0d with empty scoreboard", o_clk_count, o_stop_cause);
        end else begin
          e = sb.pop_front();
          if (o_clk_count !== e.count || o_stop_cause !== e.cause) begin
            errors++;
            $display("FAIL sb_send got count=%0d cause=%0d expected count=%0d cause=%0d",
                     o_clk_count, o_stop_cause, e.count, e.cause);
          end
        end
      end
    end
  end

  task automatic drive_idle();
    i_start = 1'b0; i_mode = 2'd0; i_step = 1'b0; i_abort = 1'b0;
    i_bp_en = 1'b0; i_bp_addr = 32'd0; i_pc = 32'd0;
    i_instruction = NOP; i_send_done = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({o_enable, o_send_start, o_busy, o_done, o_stop_cause, o_clk_count, s_clk_count} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs en=%b ss=%b busy=%b done=%b cause=%0d count=%0d expected all 0",
               o_enable, o_send_start, o_busy, o_done, o_stop_cause, o_clk_count);
    end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_continuous();
    logic [3:0] exp_v;
    sb.push_back('{count: 32'd8, cause: 2'd1});
    for (int c = 0; c <= 14; c++) begin
      i_start       = (c == 0);
      i_mode        = 2'd0;
      i_instruction = (c >= 6) ? HLT : NOP;
      i_send_done   = (c == 12);
      exp_v = {(c >= 1 && c <= 8), (c == 9), (c == 13), (c >= 1 && c <= 13)};
      @(negedge clk);
      checks++;
      if ({o_enable, o_send_start, o_done, o_busy} !== exp_v) begin
        errors++;
        $display("FAIL cont_moore cycle %0d got en/ss/done/busy=%b expected %b", c,
                 {o_enable, o_send_start, o_done, o_busy}, exp_v);
      end
      next_cycle();
    end
    checks++;
    if (o_clk_count !== 32'd8) begin
      errors++;
      $display("FAIL cont_count_hold got %0d expected 8", o_clk_count);
    end
    drive_idle();
  endtask

  task automatic test_hlt_blip();
    logic [3:0] exp_v;
    sb.push_back('{count: 32'd8, cause: 2'd3});
    for (int c = 0; c <= 12; c++) begin
      i_start       = (c == 0 || c == 4);
      i_mode        = (c == 0) ? 2'd3 : 2'd1;
      i_instruction = (c == 3) ? HLT : NOP;
      i_abort       = (c == 8);
      i_send_done   = (c == 10);
      exp_v = {(c >= 1 && c <= 8), (c == 9), (c == 11), (c >= 1 && c <= 11)};
      @(negedge clk);
      checks++;
      if ({o_enable, o_send_start, o_done, o_busy} !== exp_v) begin
        errors++;
        $display("FAIL blip_moore cycle %0d got %b expected %b", c,
                 {o_enable, o_send_start, o_done, o_busy}, exp_v);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_breakpoint();
    logic [3:0] exp_v;
    sb.push_back('{count: 32'd5, cause: 2'd2});
    for (int c = 0; c <= 9; c++) begin
      i_start     = (c == 0);
      i_mode      = 2'd2;
      i_bp_en     = 1'b1;
      i_bp_addr   = 32'h10;
      i_pc        = (c == 5) ? 32'h10 : 32'h100 + 32'(c);
      i_send_done = (c == 8);
      exp_v = {(c >= 1 && c <= 5), (c == 6), (c == 9), (c >= 1 && c <= 9)};
      @(negedge clk);
      checks++;
      if ({o_enable, o_send_start, o_done, o_busy} !== exp_v) begin
        errors++;
        $display("FAIL bp_moore cycle %0d got %b expected %b", c,
                 {o_enable, o_send_start, o_done, o_busy}, exp_v);
      end
      next_cycle();
    end
    drive_idle();
    // Same match with the breakpoint disabled must not stop the run.
    sb.push_back('{count: 32'd8, cause: 2'd3});
    for (int c = 0; c <= 11; c++) begin
      i_start     = (c == 0);
      i_mode      = 2'd2;
      i_bp_en     = 1'b0;
      i_bp_addr   = 32'h10;
      i_pc        = (c == 5) ? 32'h10 : 32'h100 + 32'(c);
      i_abort     = (c == 8);
      i_send_done = (c == 10);
      exp_v = {(c >= 1 && c <= 8), (c == 9), (c == 11), (c >= 1 && c <= 11)};
      @(negedge clk);
      checks++;
      if ({o_enable, o_send_start, o_done, o_busy} !== exp_v) begin
        errors++;
        $display("FAIL bp_off_moore cycle %0d got %b expected %b", c,
                 {o_enable, o_send_start, o_done, o_busy}, exp_v);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_step();
    logic [3:0] exp_v;
    sb.push_back('{count: 32'd1, cause: 2'd0});
    sb.push_back('{count: 32'd2, cause: 2'd0});
    sb.push_back('{count: 32'd3, cause: 2'd0});
    sb.push_back('{count: 32'd3, cause: 2'd3});
    for (int c = 0; c <= 22; c++) begin
      i_start     = (c == 0);
      i_mode      = 2'd1;
      i_step      = (c == 2 || c == 5 || c == 7 || c == 12 || c == 17);
      i_abort     = (c == 17);
      i_send_done = (c == 5 || c == 10 || c == 15 || c == 20);
      exp_v = {(c == 3 || c == 8 || c == 13), (c == 4 || c == 9 || c == 14 || c == 18),
               (c == 21), (c >= 1 && c <= 21)};
      @(negedge clk);
      checks++;
      if ({o_enable, o_send_start, o_done, o_busy} !== exp_v) begin
        errors++;
        $display("FAIL step_moore cycle %0d got %b expected %b", c,
                 {o_enable, o_send_start, o_done, o_busy}, exp_v);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_step_halt();
    logic [3:0] exp_v;
    sb.push_back('{count: 32'd1, cause: 2'd0});
    sb.push_back('{count: 32'd2, cause: 2'd0});
    sb.push_back('{count: 32'd3, cause: 2'd1});
    for (int c = 0; c <= 17; c++) begin
      i_start       = (c == 0);
      i_mode        = 2'd1;
      i_instruction = HLT;
      i_step        = (c == 2 || c == 7 || c == 12);
      i_send_done   = (c == 5 || c == 10 || c == 15);
      exp_v = {(c == 3 || c == 8 || c == 13), (c == 4 || c == 9 || c == 14),
               (c == 16), (c >= 1 && c <= 16)};
      @(negedge clk);
      checks++;
      if ({o_enable, o_send_start, o_done, o_busy} !== exp_v) begin
        errors++;
        $display("FAIL step_halt_moore cycle %0d got %b expected %b", c,
                 {o_enable, o_send_start, o_done, o_busy}, exp_v);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_abort();
    logic [3:0] exp_v;
    sb.push_back('{count: 32'd2, cause: 2'd3});
    for (int c = 0; c <= 8; c++) begin
      i_start       = (c == 0);
      i_mode        = 2'd0;
      i_instruction = (c >= 2) ? HLT : NOP;
      i_abort       = (c == 2 || c == 3);
      i_send_done   = (c == 3 || c == 6);
      exp_v = {(c >= 1 && c <= 2), (c == 3), (c == 7), (c >= 1 && c <= 7)};
      @(negedge clk);
      checks++;
      if ({o_enable, o_send_start, o_done, o_busy} !== exp_v) begin
        errors++;
        $display("FAIL abort_moore cycle %0d got %b expected %b", c,
                 {o_enable, o_send_start, o_done, o_busy}, exp_v);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_v;
    sb.push_back('{count: 32'd2, cause: 2'd3});
    for (int c = 0; c <= 6; c++) begin
      i_start = (c == 0);
      i_abort = (c == 2);
      rst     = (c == 5);
      exp_v = {(c >= 1 && c <= 2), (c == 3), 1'b0, (c >= 1 && c <= 5)};
      @(negedge clk);
      checks++;
      if ({o_enable, o_send_start, o_done, o_busy} !== exp_v) begin
        errors++;
        $display("FAIL rst_mid_moore cycle %0d got %b expected %b", c,
                 {o_enable, o_send_start, o_done, o_busy}, exp_v);
      end
      next_cycle();
    end
    checks++;
    if ({o_stop_cause, o_clk_count} !== 34'd0) begin
      errors++;
      $display("FAIL rst_mid_regs got cause=%0d count=%0d expected 0 0", o_stop_cause, o_clk_count);
    end
    drive_idle();
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    logic [3:0] exp_v;
    sb.push_back('{count: 32'd21, cause: 2'd3});
    for (int c = 0; c <= 24; c++) begin
      i_start     = (c == 0);
      i_abort     = (c == 21);
      i_send_done = (c == 23);
      exp_v = {(c >= 1 && c <= 21), (c == 22), (c == 24), (c >= 1 && c <= 24)};
      @(negedge clk);
      checks++;
      if ({o_enable, o_send_start, o_done, o_busy} !== exp_v) begin
        errors++;
        $display("FAIL sat_moore cycle %0d got %b expected %b", c,
                 {o_enable, o_send_start, o_done, o_busy}, exp_v);
      end
      if (c == 21) begin
        checks++;
        if (o_clk_count !== 32'd20 || s_clk_count !== 4'hF ||
            {s_enable, s_send_start, s_done, s_busy} !== 4'b1001) begin
          errors++;
          $display("FAIL sat_count got wide=%0d narrow=%0d narrow_flags=%b expected 20 15 1001",
                   o_clk_count, s_clk_count, {s_enable, s_send_start, s_done, s_busy});
        end
      end
      if (c == 22) begin
        checks++;
        if (s_clk_count !== 4'hF || s_stop_cause !== 2'd3) begin
          errors++;
          $display("FAIL sat_hold got narrow=%0d cause=%0d expected 15 3", s_clk_count, s_stop_cause);
        end
      end
      next_cycle();
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_continuous();
    test_hlt_blip();
    test_breakpoint();
    test_step();
    test_step_halt();
    test_abort();
    test_reset_mid();
    test_saturation();
    next_cycle();
    next_cycle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending records expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
